// File: rtl/serializer.sv
// Parallel-to-serial converter: MSB-first bit stream with a one-word holding
// buffer so consecutive words stream without an idle cycle between them.
module serializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ready_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  buf_data;
    logic [CNT_W-1:0]   buf_len;
    logic               buf_valid;

    logic               accept;
    logic [CNT_W-1:0]   in_len;
    logic               in_keep;
    logic               last_bit;
    logic               load_in;
    logic               load_buf;
    logic               store_buf;

    // Words of length 1 or 2 are consumed by the handshake but never transmitted.
    always_comb begin
        accept    = data_val_i && ready_o;
        in_len    = (data_mod_i == '0) ? CNT_W'(DATA_W) : CNT_W'(data_mod_i);
        in_keep   = in_len >= CNT_W'(3);
        last_bit  = (state == SHIFT) && (cnt == '0);
        load_buf  = last_bit && buf_valid;
        load_in   = accept && in_keep && ((state == IDLE) || last_bit);
        store_buf = accept && in_keep && (state == SHIFT) && !last_bit;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load_in) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit && !load_buf && !load_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = !buf_valid && !srst_i;
        busy_o  = (state == SHIFT) || buf_valid;
    end

    // The output register always shows the current bit; shift_reg holds the
    // bits still to come and cnt counts them, so cnt==0 marks the last bit.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            shift_reg      <= '0;
            cnt            <= '0;
            buf_data       <= '0;
            buf_len        <= '0;
            buf_valid      <= 1'b0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
        end else begin
            if (load_buf) begin
                ser_data_o     <= buf_data[DATA_W-1];
                ser_data_val_o <= 1'b1;
                shift_reg      <= buf_data << 1;
                cnt            <= buf_len - CNT_W'(1);
                buf_valid      <= 1'b0;
            end else if (load_in) begin
                ser_data_o     <= data_i[DATA_W-1];
                ser_data_val_o <= 1'b1;
                shift_reg      <= data_i << 1;
                cnt            <= in_len - CNT_W'(1);
            end else if ((state == SHIFT) && !last_bit) begin
                ser_data_o     <= shift_reg[DATA_W-1];
                ser_data_val_o <= 1'b1;
                shift_reg      <= shift_reg << 1;
                cnt            <= cnt - CNT_W'(1);
            end else begin
                ser_data_o     <= 1'b0;
                ser_data_val_o <= 1'b0;
            end

            if (store_buf) begin
                buf_data  <= data_i;
                buf_len   <= in_len;
                buf_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: bit-queue reference model, directed
// scenarios and a randomized loopback with word reassembly.
module tb_serializer;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_val_i;
    logic        ready_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted bit waits in a queue tagged with its word id.
    logic        q_bits[$];
    int          q_id[$];
    int          cur_id = -1;
    int          next_id = 0;
    logic        exp_ser = 1'b0;
    logic        exp_val = 1'b0;
    logic        accepted = 1'b0;

    logic [31:0] cap = '0;
    int          cap_cnt = 0;
    int          run = 0;
    int          max_run = 0;
    logic        deser_on = 1'b0;
    logic [15:0] sent_q[$];
    int          words_rx = 0;

    serializer #(.DATA_W(16), .MOD_W(4)) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ready_o        (ready_o),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // A word is waiting behind the one on the wire when queued bits belong to another word.
    function automatic logic model_buf();
        if (q_bits.size() == 0) return 1'b0;
        return q_id[$] != cur_id;
    endfunction

    function automatic logic model_ready();
        return !srst_i && !model_buf();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic rdy;
        int   len;
        rdy      = model_ready();
        accepted = 1'b0;
        if (srst_i) begin
            q_bits.delete();
            q_id.delete();
            exp_val = 1'b0;
            exp_ser = 1'b0;
            cur_id  = -1;
        end else begin
            if (data_val_i && rdy) begin
                accepted = 1'b1;
                len = (data_mod_i == 4'd0) ? 16 : int'(data_mod_i);
                if (len >= 3) begin
                    for (int i = 0; i < len; i++) begin
                        q_bits.push_back(data_i[15-i]);
                        q_id.push_back(next_id);
                    end
                    next_id++;
                end
                if (deser_on) sent_q.push_back(data_i);
            end
            if (q_bits.size() > 0) begin
                exp_ser = q_bits.pop_front();
                cur_id  = q_id.pop_front();
                exp_val = 1'b1;
            end else begin
                exp_ser = 1'b0;
                exp_val = 1'b0;
            end
        end
    endtask

    task automatic check_output();
        logic [15:0] w;
        chk("ser_data_o", 32'(ser_data_o), 32'(exp_ser));
        chk("ser_data_val_o", 32'(ser_data_val_o), 32'(exp_val));
        chk("busy_o", 32'(busy_o), 32'(exp_val || model_buf()));
        chk("ready_o", 32'(ready_o), 32'(model_ready()));
        if (ser_data_val_o === 1'b1) begin
            cap = {cap[30:0], ser_data_o};
            cap_cnt++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (deser_on && cap_cnt == 16) begin
            cap_cnt = 0;
            words_rx++;
            if (sent_q.size() == 0) begin
                chk("deser_unexpected_word", cap[31:0], 32'hDEAD_BEEF);
            end else begin
                w = sent_q.pop_front();
                chk("deser_word", {16'h0, cap[15:0]}, {16'h0, w});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_output();
    endtask

    task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] m, input logic v);
        data_i     = d;
        data_mod_i = m;
        data_val_i = v;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(16'h0, 4'd0, 1'b0);
    endtask

    task automatic clear_capture();
        cap     = '0;
        cap_cnt = 0;
        run     = 0;
        max_run = 0;
    endtask

    initial begin
        int budget;
        srst_i     = 1'b1;
        data_i     = '0;
        data_mod_i = '0;
        data_val_i = 1'b0;
        @(negedge clk_i);
        idle(2);
        chk("reset_ready_low", 32'(ready_o), 32'h0);
        srst_i = 1'b0;
        idle(1);
        chk("ready_after_reset", 32'(ready_o), 32'h1);

        $display("[TB] full 16-bit word A5C3");
        clear_capture();
        apply_stimulus(16'hA5C3, 4'd0, 1'b1);
        idle(18);
        chk("a5c3_stream", {16'h0, cap[15:0]}, 32'h0000_A5C3);
        chk("a5c3_valid_cycles", 32'(cap_cnt), 32'd16);
        chk("a5c3_busy_after", 32'(busy_o), 32'h0);

        $display("[TB] short word F000 mod 5");
        clear_capture();
        apply_stimulus(16'hF000, 4'd5, 1'b1);
        idle(8);
        chk("f000_stream", {27'h0, cap[4:0]}, 32'h1E);
        chk("f000_valid_cycles", 32'(cap_cnt), 32'd5);

        $display("[TB] discarded mod 1 and mod 2 words");
        clear_capture();
        apply_stimulus(16'hFFFF, 4'd1, 1'b1);
        apply_stimulus(16'hFFFF, 4'd2, 1'b1);
        idle(3);
        chk("discard_no_output", 32'(cap_cnt), 32'd0);
        chk("discard_ready", 32'(ready_o), 32'h1);

        $display("[TB] back-to-back 8001 / 7FFE");
        clear_capture();
        apply_stimulus(16'h8001, 4'd0, 1'b1);
        apply_stimulus(16'h7FFE, 4'd0, 1'b1);
        chk("b2b_ready_low", 32'(ready_o), 32'h0);
        idle(34);
        chk("b2b_stream", cap, 32'h8001_7FFE);
        chk("b2b_contiguous", 32'(max_run), 32'd32);

        $display("[TB] reset mid-word with buffered word");
        clear_capture();
        apply_stimulus(16'hFFFF, 4'd0, 1'b1);
        apply_stimulus(16'hFFFF, 4'd0, 1'b1);
        idle(6);
        srst_i = 1'b1;
        idle(1);
        chk("rst_mid_val", 32'(ser_data_val_o), 32'h0);
        chk("rst_mid_busy", 32'(busy_o), 32'h0);
        srst_i = 1'b0;
        idle(1);
        chk("rst_mid_ready", 32'(ready_o), 32'h1);
        clear_capture();
        idle(20);
        chk("rst_mid_no_output", 32'(cap_cnt), 32'd0);

        $display("[TB] random loopback, 100 words");
        clear_capture();
        deser_on = 1'b1;
        for (int n = 0; n < 100; n++) begin
            idle(int'($urandom_range(0, 3)));
            budget = 0;
            data_i     = 16'($urandom);
            data_mod_i = 4'd0;
            data_val_i = 1'b1;
            do begin
                tick();
                budget++;
            end while (!accepted && budget < 40);
            if (!accepted) chk("accept_timeout", 32'(budget), 32'd0);
            data_val_i = 1'b0;
        end
        idle(40);
        chk("loopback_words", 32'(words_rx), 32'd100);
        chk("loopback_drained", 32'(sent_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
